// File: rtl/l0_ram_port_arbiter.sv
// Single SP RAM port arbiter between instr_cache_L0 (IC) and a data/DMA requester (DP),
// with in-order owner tracking for responses. Optional DP anti-starvation: define ARB_AGING_EN.
module l0_ram_port_arbiter #(
    parameter int unsigned RAM_WIDTH       = 128,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned AGE_LIMIT       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ic_en_i,
    input  logic [31:0]            ic_addr_i,
    output logic                   ic_gnt_o,
    output logic                   ic_rvalid_o,
    output logic [RAM_WIDTH-1:0]   ic_rdata_o,
    input  logic                   dp_en_i,
    input  logic [31:0]            dp_addr_i,
    input  logic                   dp_we_i,
    input  logic [RAM_WIDTH/8-1:0] dp_be_i,
    input  logic [RAM_WIDTH-1:0]   dp_wdata_i,
    output logic                   dp_gnt_o,
    output logic                   dp_rvalid_o,
    output logic [RAM_WIDTH-1:0]   dp_rdata_o,
    output logic                   ram_en_o,
    output logic [31:0]            ram_addr_o,
    output logic                   ram_we_o,
    output logic [RAM_WIDTH/8-1:0] ram_be_o,
    output logic [RAM_WIDTH-1:0]   ram_wdata_o,
    input  logic                   ram_gnt_i,
    input  logic                   ram_rvalid_i,
    input  logic [RAM_WIDTH-1:0]   ram_rdata_i,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_IC,
        ARB_HOLD_DP
    } arb_state_e;

    arb_state_e                 state_q, state_d;
    logic                       err_q, err_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic sel_dp;
    logic req;
    logic fifo_full;
    logic grant;
    logic pop;
    logic head_dp;
    logic age_force;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q, age_d;

    assign age_force = (age_q == AGE_W'(AGE_LIMIT));

    always_comb begin
        age_d = age_q;
        if (dp_gnt_o) begin
            age_d = '0;
        end else if (dp_en_i && !age_force) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign age_force = 1'b0 & (AGE_LIMIT == 0);
`endif

    // A locked selection ignores the other requester until the grant or an abandon.
    always_comb begin
        case (state_q)
            ARB_HOLD_IC: begin
                sel_dp = 1'b0;
                req    = ic_en_i;
            end
            ARB_HOLD_DP: begin
                sel_dp = 1'b1;
                req    = dp_en_i;
            end
            default: begin
                sel_dp = dp_en_i & (~ic_en_i | age_force);
                req    = ic_en_i | dp_en_i;
            end
        endcase
    end

    // A response in the same cycle frees a slot, so a full FIFO can still accept a grant.
    assign fifo_full = (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~ram_rvalid_i;
    assign ram_en_o  = req & ~fifo_full;
    assign grant     = ram_en_o & ram_gnt_i;
    assign ic_gnt_o  = grant & ~sel_dp;
    assign dp_gnt_o  = grant & sel_dp;

    assign ram_addr_o  = sel_dp ? dp_addr_i : ic_addr_i;
    assign ram_we_o    = sel_dp & dp_we_i;
    assign ram_be_o    = sel_dp ? dp_be_i : '1;
    assign ram_wdata_o = sel_dp ? dp_wdata_i : '0;

    assign pop         = ram_rvalid_i & (cnt_q != '0);
    assign head_dp     = owner_q[rd_ptr_q];
    assign ic_rvalid_o = pop & ~head_dp;
    assign dp_rvalid_o = pop & head_dp;
    assign ic_rdata_o  = ram_rdata_i;
    assign dp_rdata_o  = ram_rdata_i;
    assign err_o       = err_q;

    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (grant) begin
            owner_d[wr_ptr_q] = sel_dp;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (ram_rvalid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ARB_IDLE: begin
                if (req && !grant) begin
                    state_d = sel_dp ? ARB_HOLD_DP : ARB_HOLD_IC;
                end
            end
            ARB_HOLD_IC, ARB_HOLD_DP: begin
                if (grant) begin
                    state_d = ARB_IDLE;
                end else if (!req) begin
                    state_d = ARB_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_l0_ram_port_arbiter.sv
// Self-checking bench for l0_ram_port_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based behavioural model of the arbitration rules.
module tb_l0_ram_port_arbiter;

    localparam int RW = 128;
    localparam int BW = RW / 8;
    localparam int MO = 2;
    localparam int AL = 8;

    logic          clk;
    logic          rst;
    logic          ic_en, ic_gnt, ic_rvalid;
    logic [31:0]   ic_addr;
    logic [RW-1:0] ic_rdata;
    logic          dp_en, dp_we, dp_gnt, dp_rvalid;
    logic [31:0]   dp_addr;
    logic [BW-1:0] dp_be;
    logic [RW-1:0] dp_wdata, dp_rdata;
    logic          ram_en, ram_we, ram_gnt, ram_rvalid;
    logic [31:0]   ram_addr;
    logic [BW-1:0] ram_be;
    logic [RW-1:0] ram_wdata, ram_rdata;
    logic          err;

    l0_ram_port_arbiter #(
        .RAM_WIDTH      (RW),
        .MAX_OUTSTANDING(MO),
        .AGE_LIMIT      (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_en_i     (ic_en),
        .ic_addr_i   (ic_addr),
        .ic_gnt_o    (ic_gnt),
        .ic_rvalid_o (ic_rvalid),
        .ic_rdata_o  (ic_rdata),
        .dp_en_i     (dp_en),
        .dp_addr_i   (dp_addr),
        .dp_we_i     (dp_we),
        .dp_be_i     (dp_be),
        .dp_wdata_i  (dp_wdata),
        .dp_gnt_o    (dp_gnt),
        .dp_rvalid_o (dp_rvalid),
        .dp_rdata_o  (dp_rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_gnt_i   (ram_gnt),
        .ram_rvalid_i(ram_rvalid),
        .ram_rdata_i (ram_rdata),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding owners (0=IC, 1=DP), locked requester (0 none, 1 IC, 2 DP).
    bit owners[$];
    int lock_who;
    bit m_err;
    int age;

    logic e_sel, e_req, e_en, e_gnt, e_ic_gnt, e_dp_gnt, e_pop, e_ic_rv, e_dp_rv;
    logic obs_dp_gnt;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_comb();
        bit aging_win;
`ifdef ARB_AGING_EN
        aging_win = (age >= AL);
`else
        aging_win = 1'b0;
`endif
        if (lock_who == 1) begin
            e_sel = 1'b0;
            e_req = ic_en;
        end else if (lock_who == 2) begin
            e_sel = 1'b1;
            e_req = dp_en;
        end else begin
            e_req = ic_en | dp_en;
            e_sel = dp_en && (!ic_en || aging_win);
        end
        e_en     = e_req && !((owners.size() == MO) && !ram_rvalid);
        e_gnt    = e_en && ram_gnt;
        e_ic_gnt = e_gnt && !e_sel;
        e_dp_gnt = e_gnt && e_sel;
        e_pop    = ram_rvalid && (owners.size() > 0);
        e_ic_rv  = e_pop && (owners[0] == 1'b0);
        e_dp_rv  = e_pop && (owners[0] == 1'b1);
    endtask

    task automatic tick();
        #4;
        model_comb();
        obs_dp_gnt = dp_gnt;
        chk("ram_en", RW'(ram_en), RW'(e_en));
        chk("ic_gnt", RW'(ic_gnt), RW'(e_ic_gnt));
        chk("dp_gnt", RW'(dp_gnt), RW'(e_dp_gnt));
        chk("ic_rvalid", RW'(ic_rvalid), RW'(e_ic_rv));
        chk("dp_rvalid", RW'(dp_rvalid), RW'(e_dp_rv));
        chk("err", RW'(err), RW'(m_err));
        if (e_req) begin
            chk("ram_addr", RW'(ram_addr), RW'(e_sel ? dp_addr : ic_addr));
            chk("ram_we", RW'(ram_we), RW'(e_sel ? dp_we : 1'b0));
            chk("ram_be", RW'(ram_be), RW'(e_sel ? dp_be : {BW{1'b1}}));
            chk("ram_wdata", ram_wdata, e_sel ? dp_wdata : '0);
        end
        if (e_ic_rv) chk("ic_rdata", ic_rdata, ram_rdata);
        if (e_dp_rv) chk("dp_rdata", dp_rdata, ram_rdata);
        @(posedge clk);
        if (rst) begin
            owners.delete();
            lock_who = 0;
            m_err    = 1'b0;
            age      = 0;
        end else begin
            if (ram_rvalid && owners.size() == 0) m_err = 1'b1;
            if (e_pop) void'(owners.pop_front());
            if (e_gnt) owners.push_back(e_sel);
            if (lock_who == 0) begin
                if (e_req && !e_gnt) lock_who = e_sel ? 2 : 1;
            end else if (e_gnt) begin
                lock_who = 0;
            end else if (!e_req) begin
                lock_who = 0;
                m_err    = 1'b1;
            end
            if (e_dp_gnt) age = 0;
            else if (dp_en && age < AL) age++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ic_en = 0; dp_en = 0; dp_we = 0; ram_gnt = 0; ram_rvalid = 0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int n = 0; n < 10 && owners.size() > 0; n++) begin
            ram_rvalid = 1; ram_rdata = {4{$urandom}};
            tick();
        end
        ram_rvalid = 0;
        chk("drain_empty", RW'(owners.size()), RW'(0));
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        int first_dp;
        int exp_first;
        lock_who = 0; m_err = 0; age = 0;
        ic_addr = 32'h0; dp_addr = 32'h0; dp_be = '0; dp_wdata = '0; ram_rdata = '0;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        chk("reset_ram_en", RW'(ram_en), RW'(0));
        chk("reset_err", RW'(err), RW'(0));

        // T1: simultaneous requests, IC wins, response routed to IC
        ic_en = 1; ic_addr = 32'h0000_0040; dp_en = 1; dp_addr = 32'h0000_0200; ram_gnt = 1;
        tick();
        ic_en = 0; dp_en = 0; ram_gnt = 0; ram_rvalid = 1; ram_rdata = {4{32'hA5A5_0001}};
        tick();
        ram_rvalid = 0;
        tick();

        // T2: DP locked while RAM stalls; IC arrives later and waits
        dp_en = 1; dp_addr = 32'h0000_0100; dp_we = 0; dp_be = '1; ram_gnt = 0;
        tick();
        ic_en = 1; ic_addr = 32'h0000_0080;
        tick();
        tick();
        ram_gnt = 1;
        tick();
        chk("T2_dp_gnt_c3", RW'(obs_dp_gnt), RW'(1));
        dp_en = 0;
        tick();
        drain();

        // T3: fill the owner FIFO, then push and pop in the same cycle
        ic_en = 1; ic_addr = 32'h0000_1000; ram_gnt = 1;
        tick();
        tick();
        tick();
        chk("T3_full_blocks", RW'(ram_en), RW'(0));
        ram_rvalid = 1; ram_rdata = {4{32'h1234_5678}};
        tick();
        chk("T3_count_stays_full", RW'(owners.size()), RW'(MO));
        drain();
        tick();

        // T4: IC, DP write, IC; responses in grant order
        ic_en = 1; ic_addr = 32'h0000_2000; ram_gnt = 1;
        tick();
        ic_en = 0; dp_en = 1; dp_we = 1; dp_addr = 32'h0000_3000;
        dp_be = BW'($urandom); dp_wdata = {$urandom, $urandom, $urandom, $urandom};
        ram_rvalid = 1; ram_rdata = {4{32'h0BAD_F00D}};
        tick();
        dp_en = 0; dp_we = 0; ic_en = 1; ic_addr = 32'h0000_2010;
        tick();
        ic_en = 0; ram_gnt = 0;
        tick();
        drain();

        // T5: sustained contention, DP only wins through aging
        do_reset();
        ic_en = 1; dp_en = 1; ram_gnt = 1; ic_addr = 32'h0000_4000; dp_addr = 32'h0000_5000;
        first_dp = 0;
        for (int c = 1; c <= 20; c++) begin
            ram_rvalid = (owners.size() > 0);
            ram_rdata = {4{$urandom}};
            tick();
            if (obs_dp_gnt && first_dp == 0) first_dp = c;
        end
`ifdef ARB_AGING_EN
        exp_first = 9;
`else
        exp_first = 0;
`endif
        chk("T5_first_dp_gnt", RW'(first_dp), RW'(exp_first));
        drain();

        // T6: response with nothing outstanding is a sticky error
        ram_rvalid = 1;
        tick();
        ram_rvalid = 0;
        tick();
        tick();
        chk("T6_err_sticky", RW'(err), RW'(1));
        do_reset();
        tick();
        chk("T6_err_cleared", RW'(err), RW'(0));

        // Locked requester abandoning its request
        dp_en = 1; dp_addr = 32'h0000_6000; ram_gnt = 0;
        tick();
        dp_en = 0;
        tick();
        chk("abandon_err", RW'(err), RW'(1));
        do_reset();

        // Random traffic with well-behaved requesters
        for (int c = 0; c < 500; c++) begin
            if (!ic_en && ($urandom % 3 == 0)) begin
                ic_en = 1; ic_addr = $urandom & 32'hFFFF_FFF0;
            end
            if (!dp_en && ($urandom % 3 == 0)) begin
                dp_en = 1; dp_addr = $urandom; dp_we = $urandom % 2;
                dp_be = BW'($urandom); dp_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            ram_gnt    = ($urandom % 10) < 6;
            ram_rvalid = (owners.size() > 0) && ($urandom % 2 == 1);
            ram_rdata  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (e_ic_gnt) ic_en = 0;
            if (e_dp_gnt) dp_en = 0;
        end
        drain();
        chk("random_no_err", RW'(err), RW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
